alu_result_fifo: RTL
====================

# alu_result_fifo

Downstream capture stage for the ALU. Samples each valid ALU result (`outp`) together with the `op_code` that produced it, buffers up to DEPTH entries in a show-ahead FIFO, and presents them to the consumer over a valid/ready handshake. It decouples the ALU, which cannot stall, from a slower sink and flags any result lost to overflow.

## Interface
- N, 4: ALU operand width; result width is 2*N.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the ALU result on in_outp/in_op_code is valid this cycle.
- in_op_code  input  2  op_code that produced the result.
- in_outp  input  2*N  ALU result.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  2*N+2  head entry, {op_code, outp}.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a valid result was dropped.
- stat_cnt  output  4*8  only with ALU_FIFO_STATS_EN; per-opcode accepted-entry counters. Opcode k occupies bits [8k+7:8k].

## Operation
- Storage: DEPTH x (2*N+2) array, read pointer and write pointer of $clog2(DEPTH) bits, and a registered count.
- Pointers wrap from DEPTH-1 to 0 with natural modulo. The array itself is not reset.
- pop = out_valid && out_ready.
- push = in_valid && (!full || pop). A write into a full FIFO is accepted when a pop occurs in the same cycle.
- On push: mem[wr_ptr] <= {in_op_code, in_outp}; wr_ptr increments.
- On pop: rd_ptr increments.
- count updates as follows:
  - push only: count+1.
  - pop only: count-1.
  - both or neither: count unchanged.
- out_valid = !empty. out_data = mem[rd_ptr] when out_valid is 1, otherwise all zeros (show-ahead).
- full and empty decode combinationally from registered count.
- Drop: in_valid && full && !pop. The entry is discarded, storage is untouched, and overflow is set to 1. overflow holds until reset.
- Empty FIFO has no bypass: a push to an empty FIFO is not visible on out_data in the same cycle.
- out_data must stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset is synchronous. At the first clk edge with reset=1:
  - count=0, rd_ptr=0, wr_ptr=0, overflow=0, stat_cnt=0.
  - Consequently out_valid=0, out_data=0, empty=1, full=0.
- Reset asserted mid-operation discards all stored entries at that edge. in_valid is ignored while reset=1.
- Latency: a result pushed at edge t appears with out_valid=1 after edge t. Minimum in-to-out latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained, at any fill level including full.
- Ordering is strict FIFO. There is no reordering by op_code.
- The ALU has no backpressure. The block never stalls it, and in_valid carries no ready signal.

## Configuration
- ALU_FIFO_STATS_EN defined:
  - Adds stat_cnt: four 8-bit counters indexed by in_op_code.
  - A counter increments on each accepted push with that op_code.
  - Counters saturate at 255, do not count dropped entries, and clear on reset.
- ALU_FIFO_STATS_EN undefined: the stat_cnt port and all counter logic are absent. All other behaviour is identical.

## Test plan
- Reset, then 3 pushes of {op 0, 0x0C}, {op 1, 0x21}, {op 2, 0x30} with out_ready=0 -> count=3, out_data={0,0x0C}, which holds stable. Then out_ready=1 -> the three entries appear in order; empty=1 afterwards.
- Fill to DEPTH=8 with out_ready=0, then one more in_valid -> full=1, overflow=1, count stays 8. Draining yields the original 8 entries; the dropped entry never appears.
- Hold full with in_valid=1 and out_ready=1 for 20 cycles -> count stays 8, overflow stays 0, output data matches input stream in order across pointer wrap.
- Push 5 entries, then assert reset for 1 cycle with in_valid=1 -> next cycle count=0, out_valid=0, out_data=0, overflow=0. A subsequent push is readable as the first entry.
- Push into empty FIFO with out_ready=1 -> out_valid=0 in the push cycle, 1 in the next cycle, popped there; count returns to 0.
- With ALU_FIFO_STATS_EN: 300 accepted op-3 pushes with continuous pop -> stat_cnt[31:24]=255, other counters 0. Pushes dropped while full leave the counters unchanged.

Source files
------------

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//
// Capture stage behind the ALU. Every valid ALU result is stored together
// with the op_code that produced it in a show-ahead FIFO of DEPTH entries.
// The entries are then handed to a slower consumer over a valid/ready
// handshake. The ALU cannot be stalled. A result that arrives while the FIFO
// is full, with no pop in the same cycle, is dropped, and the sticky
// overflow flag is set.
//
// Parameters
//   N      ALU operand width; results are 2*N bits wide
//   DEPTH  number of FIFO entries (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset
//   in_valid    in_outp / in_op_code carry a valid ALU result this cycle
//   in_op_code  op_code that produced the result
//   in_outp     ALU result
//   out_valid   head entry available
//   out_ready   consumer accepts the head entry
//   out_data    head entry {op_code, outp}; all zeros when empty
//   count       number of stored entries
//   full        count == DEPTH
//   empty       count == 0
//   overflow    sticky: a valid result was dropped since reset
//   stat_cnt    per-opcode accepted-push counters, 8 bits each, saturating
//               (present only when ALU_FIFO_STATS_EN is defined)
//
// Optional feature macro: ALU_FIFO_STATS_EN
// ---------------------------------------------------------------------------
module alu_result_fifo #(
   parameter int N     = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [1:0]               in_op_code,
   input  logic [2*N-1:0]           in_outp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*N+1:0]           out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow
`ifdef ALU_FIFO_STATS_EN
   ,
   output logic [31:0]              stat_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = 2 * N + 2;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          push;
   logic          pop;
   logic          drop;

   // Status decode and handshake qualifiers. A push into a full FIFO is
   // still accepted when the head leaves in the same cycle, which is what
   // lets the FIFO sustain one-in/one-out while full.
   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == CW'(DEPTH));
      out_valid = !empty;
      pop       = out_valid && out_ready;
      push      = in_valid && (!full || pop);
      drop      = in_valid && full && !pop;
      out_data  = out_valid ? mem[rd_ptr] : '0;
   end

   assign count    = count_q;
   assign overflow = overflow_q;

   // Storage array; deliberately not reset, since only entries between the
   // pointers are ever visible on out_data.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr] <= {in_op_code, in_outp};
      end
   end

   // Pointers, occupancy and the sticky overflow flag. Pointers wrap
   // naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

`ifdef ALU_FIFO_STATS_EN
   logic [31:0] stat_q;

   // One saturating 8-bit counter per op_code; only accepted pushes count,
   // so dropped results never touch the statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_q <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (push && (in_op_code == 2'(k)) && (stat_q[8*k +: 8] != 8'hFF)) begin
               stat_q[8*k +: 8] <= stat_q[8*k +: 8] + 8'd1;
            end
         end
      end
   end

   assign stat_cnt = stat_q;
`endif

endmodule
